stage_seq: RTL
==============

STAGE_SEQ -- requirements
Module: stage_seq

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum cycles spent in MEM without i_mem_ack; legal range 2..255.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_run  input  1  high = keep issuing instructions; low = stop at the next instruction boundary.
REQ-006 i_mem_ack  input  1  memory completion for the outstanding request; sampled only in MEM.
REQ-007 o_en_if, o_en_id, o_en_ex, o_en_mem, o_en_wb  output  1 each  single-cycle stage-enable strobes.
REQ-008 o_mem_req  output  1  memory request, held high for every cycle spent in MEM.
REQ-009 o_phase  output  3  current state encoding, taken from the package.
REQ-010 o_timeout  output  1  sticky error flag, high in ERR.
REQ-011 o_retired  output  CNT_W  count of completed instructions.

Function
REQ-012 The block SHALL be an FSM with states IDLE, IF, ID, EX, MEM, WB and ERR.
REQ-013 Transitions SHALL be:
- IDLE->IF when i_run=1, otherwise stay in IDLE.
- IF->ID, ID->EX and EX->MEM unconditionally.
- MEM->WB on i_mem_ack=1.
- MEM->ERR on timeout (REQ-017).
- WB->IF when i_run=1, otherwise WB->IDLE.
- ERR SHALL persist until reset.
REQ-014 o_en_if, o_en_id, o_en_ex and o_en_wb SHALL be Moore outputs, high exactly during IF, ID, EX and WB respectively.
REQ-015 o_en_mem SHALL be high only on the MEM cycle where i_mem_ack=1.
- o_mem_req = (state==MEM).
- At most one o_en_* is high in any cycle.
REQ-016 Best-case instruction latency SHALL be 5 cycles (ack on the first MEM cycle); back-to-back instructions with i_run held high SHALL have no idle cycle between WB and IF.
REQ-017 Wait counter:
- Cleared to 0 on entry to MEM.
- Incremented on each MEM cycle without ack.
- If ack is absent while the counter equals TIMEOUT_CYCLES-1, the next state is ERR; MEM therefore lasts at most TIMEOUT_CYCLES cycles.
REQ-018 Ack arriving on the final allowed MEM cycle SHALL win over timeout (go to WB).
REQ-019 i_mem_ack in any state other than MEM SHALL be ignored, with no effect on state or counters.
REQ-020 o_retired SHALL increment by 1 on every WB cycle and wrap modulo 2^CNT_W.
REQ-021 i_run deasserted mid-instruction SHALL NOT abort it: the instruction completes through WB, then the FSM enters IDLE.
REQ-022 In ERR, all o_en_* and o_mem_req SHALL be 0, o_timeout SHALL be 1, and o_retired SHALL hold.

Reset
REQ-023 i_reset=1 SHALL, at the next rising edge, force state IDLE, wait counter 0, o_retired 0 and o_timeout 0, regardless of the current state (including MEM and ERR).
REQ-024 While in IDLE after reset, all o_en_* and o_mem_req SHALL be 0 and o_phase SHALL equal the IDLE code.
REQ-025 Reset SHALL take priority over i_run and i_mem_ack in the same cycle.

Structure
REQ-026 Package stage_seq_pkg SHALL hold:
- the state enum (3-bit, IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, ERR=7);
- default localparams for TIMEOUT_CYCLES and CNT_W.
REQ-027 The MEM wait counter SHALL be a sub-module stage_seq_wait_cnt (clear, enable, terminal-count output at TIMEOUT_CYCLES-1); all other logic SHALL be in stage_seq.

Verification
REQ-028 The bench SHALL cover:
- Reset, then i_run=1 with i_mem_ack tied high: strobes IF,ID,EX,MEM,WB on cycles 1-5 and 6-10; o_retired=2 after cycle 10.
- Ack withheld 3 MEM cycles, then asserted: o_mem_req high 4 cycles, o_en_mem on the 4th only; instruction takes 8 cycles.
- TIMEOUT_CYCLES=16, ack never asserted: o_mem_req high 16 cycles, then ERR; o_timeout=1; no strobes until i_reset.
- Ack on MEM cycle 16 exactly: WB follows, o_timeout stays 0.
- i_run dropped during ID: that instruction reaches WB; FSM then in IDLE; no further IF.
- CNT_W=4, 16 instructions: o_retired wraps 15->0; i_reset asserted during MEM: next cycle IDLE, o_retired=0.

Source files
------------

// File: rtl/stage_seq_pkg.sv
// rtl/stage_seq_pkg.sv - shared state encoding and default parameters for stage_seq
package stage_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5,
        ST_ERR  = 3'd7
    } phase_t;

    localparam int DEF_TIMEOUT_CYCLES = 16;
    localparam int DEF_CNT_W          = 16;
    localparam int WAIT_W             = 8;

endpackage

// File: rtl/stage_seq_wait_cnt.sv
// rtl/stage_seq_wait_cnt.sv - MEM wait counter with terminal count at TIMEOUT_CYCLES-1
module stage_seq_wait_cnt
    import stage_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam logic [WAIT_W-1:0] TC_VALUE = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] count;

    // Clear wins over enable so every MEM visit starts counting from zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VALUE);

endmodule

// File: rtl/stage_seq.sv
// rtl/stage_seq.sv - five-stage instruction sequencer with MEM timeout and retire counter
module stage_seq
    import stage_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run,
    input  logic             i_mem_ack,
    output logic             o_en_if,
    output logic             o_en_id,
    output logic             o_en_ex,
    output logic             o_en_mem,
    output logic             o_en_wb,
    output logic             o_mem_req,
    output logic [2:0]       o_phase,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_retired
);

    phase_t state;
    phase_t next_state;
    logic   wait_tc;
    logic   in_mem;

    assign in_mem = (state == ST_MEM);

    // Counter sits at zero outside MEM, so entry to MEM always sees a fresh count.
    stage_seq_wait_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_cnt (
        .clk  (i_clk),
        .reset(i_reset),
        .clear(!in_mem),
        .en   (in_mem && !i_mem_ack),
        .tc   (wait_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: next_state = i_run ? ST_IF : ST_IDLE;
            ST_IF:   next_state = ST_ID;
            ST_ID:   next_state = ST_EX;
            ST_EX:   next_state = ST_MEM;
            // Ack on the last allowed cycle still completes the instruction.
            ST_MEM: begin
                if (i_mem_ack) begin
                    next_state = ST_WB;
                end else if (wait_tc) begin
                    next_state = ST_ERR;
                end
            end
            ST_WB:   next_state = i_run ? ST_IF : ST_IDLE;
            ST_ERR:  next_state = ST_ERR;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_en_if   = (state == ST_IF);
        o_en_id   = (state == ST_ID);
        o_en_ex   = (state == ST_EX);
        o_en_mem  = in_mem && i_mem_ack;
        o_en_wb   = (state == ST_WB);
        o_mem_req = in_mem;
        o_timeout = (state == ST_ERR);
        o_phase   = state;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_retired <= '0;
        end else if (state == ST_WB) begin
            o_retired <= o_retired + 1'b1;
        end
    end

endmodule
